// File: rtl/fp_pad_bridge.sv
// Pad-side front end for the FP adder core: assembles operands from a narrow pad
// bus, runs the core with a completion timeout, and returns the result on the same pads.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | pads are inputs; the first valid beat starts a new frame
// S_LOAD_A| shifting in operand A beats, MS beat first
// S_LOAD_B| shifting in operand B beats, MS beat first
// S_START | one-cycle core_start pulse, operands presented to the core
// S_WAIT  | waiting for core_done or timeout
// S_DRIVE | pads are outputs; each valid acknowledges one result beat
module fp_pad_bridge #(
  parameter int PAD_W   = 8,
  parameter int OP_W    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [PAD_W-1:0]  pad_in,
  input  logic              pad_valid_i,
  input  logic              pad_sync_i,
  output logic [PAD_W-1:0]  pad_out,
  output logic [PAD_W-1:0]  pad_oeb,
  output logic              pad_ready_o,
  output logic              busy_o,
  output logic              err_o,
  output logic [OP_W-1:0]   core_a,
  output logic [OP_W-1:0]   core_b,
  output logic              core_start,
  input  logic              core_done,
  input  logic [OP_W-1:0]   core_result
);

  localparam int BEATS = OP_W / PAD_W;
  localparam int CNT_W = $clog2(BEATS + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  // B only needs to buffer BEATS-1 beats; the last one goes straight into core_b.
  localparam int RB_W  = (BEATS > 1) ? (OP_W - PAD_W) : 1;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [TMO_W-1:0] TMO_MAX   = TMO_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_START,
    S_WAIT,
    S_DRIVE
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [TMO_W-1:0]  r_tmo;
  logic [OP_W-1:0]   r_a;
  logic [RB_W-1:0]   r_b;
  logic [OP_W-1:0]   r_res;
  logic [OP_W-1:0]   r_core_a;
  logic [OP_W-1:0]   r_core_b;
  logic              r_start;
  logic              r_oeb;
  logic              r_ready;
  logic              r_busy;
  logic              r_err;

  logic [OP_W-1:0]   w_a_shift;
  logic [OP_W-1:0]   w_b_full;
  logic [RB_W-1:0]   w_b_shift;
  logic [OP_W-1:0]   w_res_shift;

  assign w_a_shift   = OP_W'({r_a, pad_in});
  assign w_b_full    = OP_W'({r_b, pad_in});
  assign w_b_shift   = RB_W'({r_b, pad_in});
  assign w_res_shift = OP_W'({r_res, {PAD_W{1'b0}}});

  assign pad_out     = r_res[OP_W-1 -: PAD_W];
  assign pad_oeb     = {PAD_W{r_oeb}};
  assign pad_ready_o = r_ready;
  assign busy_o      = r_busy;
  assign err_o       = r_err;
  assign core_a      = r_core_a;
  assign core_b      = r_core_b;
  assign core_start  = r_start;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_tmo    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_core_a <= '0;
      r_core_b <= '0;
      r_start  <= 1'b0;
      r_oeb    <= 1'b1;
      r_ready  <= 1'b1;
      r_busy   <= 1'b0;
      r_err    <= 1'b0;
    end else if (pad_sync_i) begin
      // Operands, core_a/core_b and err_o deliberately keep their values.
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_tmo   <= '0;
      r_res   <= '0;
      r_start <= 1'b0;
      r_oeb   <= 1'b1;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (pad_valid_i) begin
            r_a   <= w_a_shift;
            r_err <= 1'b0;
            if (BEATS == 1) begin
              r_cnt   <= '0;
              r_state <= S_LOAD_B;
            end else begin
              r_cnt   <= CNT_W'(1);
              r_state <= S_LOAD_A;
            end
          end
        end
        S_LOAD_A: begin
          if (pad_valid_i) begin
            r_a <= w_a_shift;
            if (r_cnt == LAST_BEAT) begin
              r_cnt   <= '0;
              r_state <= S_LOAD_B;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_LOAD_B: begin
          if (pad_valid_i) begin
            if (r_cnt == LAST_BEAT) begin
              r_cnt    <= '0;
              r_core_a <= r_a;
              r_core_b <= w_b_full;
              r_start  <= 1'b1;
              r_ready  <= 1'b0;
              r_busy   <= 1'b1;
              r_state  <= S_START;
            end else begin
              r_b   <= w_b_shift;
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_START: begin
          r_tmo   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // A done in the terminal-count cycle still wins over the timeout.
          if (core_done) begin
            r_res   <= core_result;
            r_oeb   <= 1'b0;
            r_state <= S_DRIVE;
          end else if (r_tmo == TMO_MAX) begin
            r_res   <= '1;
            r_err   <= 1'b1;
            r_oeb   <= 1'b0;
            r_state <= S_DRIVE;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        S_DRIVE: begin
          if (pad_valid_i) begin
            if (r_cnt == LAST_BEAT) begin
              r_cnt   <= '0;
              r_res   <= '0;
              r_oeb   <= 1'b1;
              r_ready <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              r_res <= w_res_shift;
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_oeb   <= 1'b1;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/fp_pad_bridge.md
# fp_pad_bridge

Parametrised pad-side front end for the floating-point adder core in the user project area. It assembles two operands from a narrow GPIO pad bus, starts the adder core, and waits for completion with a timeout. It then returns the result over the same pads, switching pad direction automatically. Pad width and operand width are generic, so the same block serves 8-bit or 16-bit pad groups and 32-bit or wider formats.

## Interface
- PAD_W, 8, pad data width; OP_W must be an integer multiple of PAD_W.
- OP_W, 32, operand and result width.
- TIMEOUT, 255, maximum cycles spent waiting for core_done; must be at least 1.
- wb_clk_i  in  1  clock; all logic rises on this edge.
- wb_rst_i  in  1  reset, asynchronous and active-high.
- pad_in  in  PAD_W  data beat from host; already synchronised.
- pad_valid_i  in  1  host strobe: data beat valid in load states, beat acknowledge in drive state.
- pad_sync_i  in  1  frame restart; returns the FSM to IDLE.
- pad_out  out  PAD_W  result beat.
- pad_oeb  out  PAD_W  pad output enable, active-low; all bits equal.
- pad_ready_o  out  1  high when the block accepts a beat (IDLE, LOAD_A, LOAD_B).
- busy_o  out  1  high in START, WAIT and DRIVE.
- err_o  out  1  sticky timeout flag; cleared by the first valid beat of a new frame.
- core_a, core_b  out  OP_W  operands to the core; held stable from START until WAIT exits.
- core_start  out  1  single-cycle start pulse.
- core_done  in  1  core completion strobe.
- core_result  in  OP_W  sampled in the cycle core_done is high.

## Operation
- BEATS = OP_W/PAD_W. A frame is BEATS beats of A, then BEATS beats of B, both most-significant beat first.
- States: IDLE, LOAD_A, LOAD_B, START, WAIT, DRIVE.
- IDLE:
  - pad_valid_i shifts pad_in into A, with A = {A[OP_W-PAD_W-1:0], pad_in}.
  - The beat counter is set to 1 and the FSM moves to LOAD_A. If BEATS==1, it moves directly to LOAD_B.
  - The same beat clears err_o.
- LOAD_A / LOAD_B:
  - Each pad_valid_i shifts in one beat and increments the counter.
  - When the count reaches BEATS, the counter wraps to 0 and the FSM advances to the next state (LOAD_A → LOAD_B, LOAD_B → START).
  - Cycles with pad_valid_i low are stalls; the counter and data hold.
- START: core_start=1 for exactly one cycle, then WAIT with the timeout counter at 0.
- WAIT:
  - core_done=1: latch core_result into the output shift register, go to DRIVE.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT, set err_o=1, load all-ones into the result register, and go to DRIVE.
  - core_done arriving in the same cycle the counter reaches TIMEOUT counts as success: err_o stays 0.
- DRIVE:
  - pad_oeb=0 and pad_out shows the result MS beat.
  - Each pad_valid_i acknowledges the current beat and shifts the next beat up.
  - The acknowledge of the last beat returns the FSM to IDLE, with pad_oeb=all-ones and pad_out=0.
- pad_sync_i in any state:
  - FSM goes to IDLE; counters clear; pad_oeb=all-ones; core_start is forced 0.
  - Operand registers, err_o and core_a/core_b hold their values.
  - pad_sync_i takes priority over a simultaneous pad_valid_i, whose beat is discarded.
- If pad_sync_i leaves a core operation in flight, the next frame's START may overlap it; a core_done seen outside WAIT is ignored.
- core_done pulses seen outside WAIT are ignored.

## Timing
- Reset values: FSM=IDLE, pad_out=0, pad_oeb=all-ones, pad_ready_o=1, busy_o=0, err_o=0, core_start=0, core_a=0, core_b=0, all counters 0.
- Reset mid-frame aborts immediately; pads return to input in the same instant (asynchronous).
- All outputs are registered or decoded from the state register; there is no combinational path from any input to any output.
- Last B beat at edge n → START state and core_start=1 from edge n+1 to edge n+2.
- core_done high at edge m → DRIVE from edge m+1, pad_oeb=0 and MS result beat valid.
- Minimum frame: 2·BEATS load cycles + 1 START + core latency + 1 + BEATS drive cycles.
- Timeout: WAIT entered at edge w → DRIVE with err_o=1 at edge w+TIMEOUT+1 if core_done never asserts.

## Test plan
- Basic add (PAD_W=8, OP_W=32, core model done 3 cycles after start):
  - Load A=0x3F800000 (1.0) and B=0x40000000 (2.0); core returns 0x40400000.
  - Required: one core_start pulse; core_a/core_b exact; pads drive 0x40,0x40,0x00,0x00 with pad_oeb=0x00; IDLE and pad_oeb=0xFF after the 4th ack; err_o=0.
- Stalled beats: insert 2 idle cycles between every load beat and every drive ack.
  - Required: identical operands and result; no beat skipped or duplicated.
- Timeout (TIMEOUT=4, core_done never asserts):
  - Required: err_o=1 and DRIVE exactly 5 cycles after WAIT is entered; pads drive 0xFF ×4.
  - The first load beat of the next frame clears err_o.
- Frame restart: pad_sync_i after 5 load beats, asserted together with a pad_valid_i.
  - Required: beat discarded, IDLE, no core_start.
  - A following full frame 0x41200000 + 0x40A00000 yields core_a=0x41200000, core_b=0x40A00000.
- Reset mid-DRIVE after 2 acks:
  - Required: pad_oeb=0xFF and pad_out=0 asynchronously; all reset values hold.
  - The next frame operates normally.
- Parameter sweep with PAD_W=16, OP_W=32:
  - Required: 2 beats per operand; result 0x40400000 driven as 0x4040, 0x0000.
